// File: rtl/regfile_dump_if.sv
// Bus between the register-file dump engine and its controller/consumer.
// Carries the start/abort controls, the register-file read port and the output stream.
interface regfile_dump_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              abort;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output start, first_addr, last_addr, abort, rf_data, out_ready,
    input  rf_addr, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport slave (
    input  start, first_addr, last_addr, abort, rf_data, out_ready,
    output rf_addr, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks a wrap-around register range through one async read port and streams
// each word, snapshotted at read time, over valid/ready.
module regfile_dump #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  regfile_dump_if.slave     bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state,     state_n;
  logic [ADDR_W-1:0] cur,       cur_n;
  logic [ADDR_W-1:0] end_addr,  end_addr_n;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_n;
  logic              valid_q,   valid_n;
  logic [DATA_W-1:0] data_q,    data_n;
  logic [ADDR_W-1:0] addr_q,    addr_n;
  logic              last_q,    last_n;
  logic              busy_q,    busy_n;
  logic              done_q,    done_n;

  // State and all output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cur       <= '0;
      end_addr  <= '0;
      rf_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      end_addr  <= end_addr_n;
      rf_addr_q <= rf_addr_n;
      valid_q   <= valid_n;
      data_q    <= data_n;
      addr_q    <= addr_n;
      last_q    <= last_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    cur_n      = cur;
    end_addr_n = end_addr;
    rf_addr_n  = rf_addr_q;
    valid_n    = valid_q;
    data_n     = data_q;
    addr_n     = addr_q;
    last_n     = last_q;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          cur_n      = bus.first_addr;
          end_addr_n = bus.last_addr;
          rf_addr_n  = bus.first_addr;
          state_n    = S_READ;
        end
      end
      S_READ: begin
        // Capture at the READ-exit edge so a same-edge write is not seen.
        data_n  = bus.rf_data;
        addr_n  = cur;
        last_n  = (cur == end_addr);
        valid_n = 1'b1;
        state_n = S_SEND;
      end
      S_SEND: begin
        if (valid_q && bus.out_ready) begin
          valid_n = 1'b0;
          if (last_q) begin
            last_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            cur_n     = cur + ADDR_W'(1);
            rf_addr_n = cur + ADDR_W'(1);
            state_n   = S_READ;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Abort wins over everything outside IDLE and drops any pending word.
    if (bus.abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      valid_n = 1'b0;
      last_n  = 1'b0;
      done_n  = 1'b0;
    end

    busy_n = (state_n != S_IDLE);
  end

  assign bus.rf_addr   = rf_addr_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// Directed scoreboard bench for regfile_dump with a behavioural 32x32 register file.
module tb_regfile_dump;
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] regs [32];
  exp_t exp_q [$];
  int checks;
  int failures;

  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rf_data = regs[bus.rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 always ready, 1 ready pattern 1,0,0,1, 2 start pulse during first SEND.
  // abort_word: index of word during whose SEND abort is raised (-1 none).
  // wr_addr: register written at the edge leaving READ of that address (-1 none).
  task automatic run_dump(input int first, input int last, input int mode,
                          input int abort_word, input int wr_addr, input logic [31:0] wr_data);
    int n, cyc, popped, stalls, k;
    bit finished, aborted, wr_done, do_wr, rdy;
    bit pat [4];
    exp_t front;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    n = ((last - first) & 31) + 1;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.a = 5'((first + i) & 31);
      e.d = regs[(first + i) & 31];
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start      = 1'b1;
    bus.first_addr = 5'(first);
    bus.last_addr  = 5'(last);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("rf_addr_after_start", 64'(bus.rf_addr), 64'(first & 31));
    popped = 0; stalls = 0; k = 0;
    finished = 1'b0; aborted = 1'b0; wr_done = 1'b0;
    while (cyc < 300 && !finished && !aborted) begin
      do_wr = 1'b0;
      if (bus.done) begin
        finished = 1'b1;
      end else begin
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(bus.out_addr), 64'hFFFF);
          end else begin
            front = exp_q[0];
            chk("out_addr", 64'(bus.out_addr), 64'(front.a));
            chk("out_data", 64'(bus.out_data), 64'(front.d));
            chk("out_last", 64'(bus.out_last), 64'(front.l));
          end
          if (abort_word == popped) begin
            bus.abort = 1'b1;
            aborted   = 1'b1;
          end else begin
            rdy = (mode == 1) ? pat[k % 4] : 1'b1;
            k++;
            if (!rdy) stalls++;
            bus.out_ready = rdy;
            if (rdy && exp_q.size() > 0) begin
              void'(exp_q.pop_front());
              popped++;
            end
            if (mode == 2 && k == 1) begin
              bus.start      = 1'b1;
              bus.first_addr = 5'(first + 3);
            end
          end
        end else if (wr_addr >= 0 && !wr_done && bus.busy && bus.rf_addr == 5'(wr_addr)) begin
          do_wr   = 1'b1;
          wr_done = 1'b1;
        end
        @(posedge clk);
        if (do_wr) regs[wr_addr] <= wr_data;
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    if (aborted) begin
      chk("abort_valid_clear", 64'(bus.out_valid), 64'd0);
      chk("abort_busy_clear", 64'(bus.busy), 64'd0);
      chk("abort_no_done", 64'(bus.done), 64'd0);
      exp_q.delete();
      @(negedge clk);
      chk("abort_no_done_later", 64'(bus.done), 64'd0);
      chk("abort_idle_valid", 64'(bus.out_valid), 64'd0);
    end else begin
      chk("done_seen", 64'(finished), 64'd1);
      chk("total_cycles", 64'(cyc), 64'(2 * n + stalls));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      chk("busy_after_done", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    int wait_cyc;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.first_addr = '0;
    bus.last_addr = '0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rf_addr", 64'(bus.rf_addr), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Abort in IDLE is ignored.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("idle_abort_busy", 64'(bus.busy), 64'd0);

    run_dump(0, 31, 0, -1, -1, 32'h0);          // full range
    run_dump(30, 1, 0, -1, -1, 32'h0);          // wrap
    run_dump(7, 7, 0, -1, -1, 32'h0);           // single word
    run_dump(3, 8, 1, -1, -1, 32'h0);           // backpressure
    run_dump(4, 6, 0, -1, 5, 32'hDEADBEEF);     // same-edge write not visible
    chk("write_landed", 64'(regs[5]), 64'hDEADBEEF);
    run_dump(5, 5, 0, -1, -1, 32'h0);           // rerun sees new value
    run_dump(12, 16, 2, -1, -1, 32'h0);         // start while busy ignored
    run_dump(20, 26, 0, 2, -1, 32'h0);          // abort on third word
    run_dump(28, 29, 0, -1, -1, 32'h0);         // restart after abort

    // Asynchronous reset mid-SEND.
    @(negedge clk);
    bus.start = 1'b1;
    bus.first_addr = 5'd10;
    bus.last_addr = 5'd12;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc = 0;
    while (!bus.out_valid && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("rst_reach_send", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_rf_addr", 64'(bus.rf_addr), 64'd0);
    chk("async_rst_out_addr", 64'(bus.out_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
      chk("post_rst_done", 64'(bus.done), 64'd0);
    end
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
